sp_ram_arbiter: RTL and testbench
=================================

SP_RAM_ARBITER -- requirements
Module: sp_ram_arbiter

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the width of the data paths (RAM din/dout, write data, read data).
REQ-002 Parameter ADDR_W, default 4, SHALL set the width of the address paths (16 locations at default).
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 reqN_valid  input  1  (N=0,1) SHALL mean requester N presents a command.
REQ-006 reqN_we  input  1  SHALL select write (1) or read (0) for requester N.
REQ-007 reqN_addr  input  ADDR_W  SHALL be requester N's RAM address.
REQ-008 reqN_wdata  input  DATA_W  SHALL be requester N's write data.
REQ-009 reqN_ready  output  1  SHALL indicate that requester N's command is accepted this cycle.
REQ-010 rspN_valid  output  1  SHALL mark a one-cycle read response for requester N.
REQ-011 rsp_data  output  DATA_W  SHALL be the shared read response data.
REQ-012 ram_ce, ram_we  output  1 each  SHALL be the RAM chip enable and write enable.
REQ-013 ram_addr  output  ADDR_W; ram_din  output  DATA_W  SHALL be the RAM address and write data.
REQ-014 ram_dout  input  DATA_W  SHALL be the RAM read data, registered inside the RAM on the edge where ram_ce=1 and ram_we=0.

Function
REQ-015 The FSM SHALL have three states: IDLE, ISSUE and RDWAIT.
REQ-016 In IDLE, a handshake SHALL occur when at least one reqN_valid=1; exactly one reqN_ready SHALL be driven high (the granted requester) in that same cycle, combinationally from the valids and the arbitration pointer.
REQ-017 reqN_ready SHALL be 0 in ISSUE and RDWAIT, and in IDLE when reqN_valid=0.
REQ-018 Arbitration SHALL be round-robin using a 1-bit last_grant register:
  - if both requesters are valid, the one not equal to last_grant SHALL be granted;
  - if only one is valid, that one SHALL be granted;
  - last_grant SHALL update to the winner on each handshake.
REQ-019 On handshake, the FSM SHALL register the command (we, addr, wdata, owner) and move to ISSUE.
REQ-020 In ISSUE:
  - ram_ce SHALL be 1;
  - ram_we, ram_addr and ram_din SHALL come from the registered command;
  - the next state SHALL be RDWAIT for a read and IDLE for a write.
REQ-021 In every state other than ISSUE, ram_ce SHALL be 0 and ram_we SHALL be 0.
REQ-022 In RDWAIT, rspN_valid SHALL be 1 for the registered owner only, rsp_data SHALL equal ram_dout, and the next state SHALL be IDLE.
REQ-023 Outside RDWAIT, rsp0_valid and rsp1_valid SHALL be 0.
REQ-024 Latency SHALL be:
  - write: handshake in cycle T, RAM write on the edge ending T+1, next handshake possible in T+2;
  - read: handshake in cycle T, rspN_valid in T+2, next handshake possible in T+3.
REQ-025 A request that is not granted SHALL remain pending while valid; because of REQ-018 it SHALL be granted no later than the next handshake, so there is no starvation.
REQ-026 Requester inputs SHALL be ignored outside the handshake cycle; later changes SHALL NOT alter a command already in flight.

Reset
REQ-027 While rst_n=0, the block SHALL hold the following, independent of clk:
  - state = IDLE and last_grant = 1, so req0 wins the first tie;
  - all registered command fields cleared to 0;
  - ram_ce=0, ram_we=0, ram_addr=0, ram_din=0, rsp0_valid=0, rsp1_valid=0.
REQ-028 Reset asserted in ISSUE or RDWAIT SHALL abort the operation with no response issued, and the aborted operation SHALL NOT be replayed after reset.

Verification
REQ-029 req0 writes 45 to address 6, then reads address 6 -> ram_ce/ram_we=1 with addr 6 and din 45 in cycle T+1; for the read, rsp0_valid=1 with rsp_data=45 exactly two cycles after the read handshake.
REQ-030 Both requesters are held valid continuously, req0 reading address 6 and req1 reading address 14 (holding 23) -> grants alternate 0,1,0,1 with req0 first after reset, and responses return 45 and 23 to the correct owners.
REQ-031 A write handshake occurs and req1_valid rises during ISSUE -> req1_ready stays 0 until IDLE, then req1 is granted two cycles after the write handshake.
REQ-032 reqN_addr and reqN_wdata are changed during ISSUE -> the RAM still sees the values captured at handshake.
REQ-033 rst_n is pulsed low during RDWAIT -> all outputs go to 0 immediately, no rspN_valid appears, and the next tie is granted to req0.

Source files
------------

// File: rtl/sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// sp_ram_arbiter
//
// Purpose
//   Two-requester round-robin arbiter in front of a single-port synchronous
//   RAM. One command is in flight at a time. The block sequences each
//   command through three states:
//     IDLE   : accept one command (combinational ready to the winner)
//     ISSUE  : drive the RAM with the registered command for one cycle
//     RDWAIT : reads only; the RAM output is returned to the owner
//   A write occupies two cycles (IDLE, ISSUE). A read occupies three
//   (IDLE, ISSUE, RDWAIT).
//
// Parameters
//   DATA_W : data width of the RAM and the requester data paths
//   ADDR_W : RAM address width
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata        requester N command (N = 0, 1)
//   reqN_ready                      command N accepted this cycle
//   rspN_valid                      one-cycle read response for requester N
//   rsp_data                        shared read response data
//   ram_ce/ram_we/ram_addr/ram_din  RAM control, address and write data
//   ram_dout                        RAM read data, registered in the RAM
// ---------------------------------------------------------------------------
module sp_ram_arbiter #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,

    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,

    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,

    output logic              ram_ce,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2
    } state_t;

    state_t              state;
    logic                last_grant;

    // Registered command, captured on the handshake only, so requester
    // inputs changing afterwards cannot disturb the operation in flight.
    logic                cmd_we;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                cmd_owner;

    // Arbitration (combinational)
    logic                hs;
    logic                win;
    logic                sel_we;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_wdata;

    always_comb begin
        hs = (state == IDLE) && (req0_valid || req1_valid);

        // On a tie, the requester that did not win last time is granted.
        // With a single valid requester, that requester wins.
        if (req0_valid && req1_valid) begin
            win = ~last_grant;
        end else begin
            win = req1_valid;
        end

        if (win) begin
            sel_we    = req1_we;
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
        end else begin
            sel_we    = req0_we;
            sel_addr  = req0_addr;
            sel_wdata = req0_wdata;
        end

        req0_ready = hs && !win;
        req1_ready = hs &&  win;
    end

    // Sequencer: command capture, RAM drive, response flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;   // req0 wins the first tie after reset
            cmd_we     <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
            cmd_owner  <= 1'b0;
            ram_ce     <= 1'b0;
            ram_we     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    if (hs) begin
                        cmd_we     <= sel_we;
                        cmd_addr   <= sel_addr;
                        cmd_wdata  <= sel_wdata;
                        cmd_owner  <= win;
                        last_grant <= win;
                        // RAM strobes are registered so they are high for
                        // exactly the ISSUE cycle.
                        ram_ce     <= 1'b1;
                        ram_we     <= sel_we;
                        state      <= ISSUE;
                    end
                end

                ISSUE: begin
                    ram_ce <= 1'b0;
                    ram_we <= 1'b0;
                    if (cmd_we) begin
                        state <= IDLE;
                    end else begin
                        // RAM registers the read on this edge; the data is
                        // valid on ram_dout during RDWAIT.
                        rsp0_valid <= ~cmd_owner;
                        rsp1_valid <=  cmd_owner;
                        state      <= RDWAIT;
                    end
                end

                RDWAIT: begin
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    state      <= IDLE;
                end

                default: begin
                    ram_ce     <= 1'b0;
                    ram_we     <= 1'b0;
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // RAM address/data come straight from the registered command; they are
    // meaningful only while ram_ce is high.
    assign ram_addr = cmd_addr;
    assign ram_din  = cmd_wdata;

    // Response data is masked outside the response cycle so the shared bus
    // reads zero whenever no response is flagged (including during reset).
    assign rsp_data = (rsp0_valid || rsp1_valid) ? ram_dout : '0;

endmodule

// File: tb/tb_sp_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sp_ram_arbiter
//
// Bench for sp_ram_arbiter. A behavioural RAM is attached to the RAM port.
// The expected behaviour comes from a transaction-level schedule: each
// accepted command books its RAM-access cycle, its response cycle and the
// first cycle at which a new command may be accepted. Read data is
// predicted from a shadow memory updated at write acceptance.
// ---------------------------------------------------------------------------
module tb_sp_ram_arbiter;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid, req0_we, req1_valid, req1_we;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic              req0_ready, req1_ready;
    logic              rsp0_valid, rsp1_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              ram_ce, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout = '0;

    always #5 clk = ~clk;

    sp_ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_we    (req0_we),
        .req0_addr  (req0_addr),
        .req0_wdata (req0_wdata),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_we    (req1_we),
        .req1_addr  (req1_addr),
        .req1_wdata (req1_wdata),
        .req1_ready (req1_ready),
        .rsp0_valid (rsp0_valid),
        .rsp1_valid (rsp1_valid),
        .rsp_data   (rsp_data),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    // Behavioural synchronous single-port RAM
    logic [DATA_W-1:0] ram_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_we) ram_mem[ram_addr] <= ram_din;
            else        ram_dout <= ram_mem[ram_addr];
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [16];
    int                cyc;
    int                op_cyc, rsp_cyc, next_free;
    bit                lg;
    bit                op_we;
    logic [ADDR_W-1:0] op_addr;
    logic [DATA_W-1:0] op_din;
    logic [DATA_W-1:0] rsp_dat;
    bit                rsp_own;
    int                grants0, grants1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        lg        = 1'b1;
        op_cyc    = -1;
        rsp_cyc   = -1;
        next_free = 0;
    endtask

    // One clock cycle: drive requests, check outputs at the falling edge,
    // advance the model, move to just after the next rising edge.
    task automatic cycle(input bit v0, input bit w0, input logic [ADDR_W-1:0] a0,
                         input logic [DATA_W-1:0] d0,
                         input bit v1, input bit w1, input logic [ADDR_W-1:0] a1,
                         input logic [DATA_W-1:0] d1);
        bit free, hs, win, cw;
        logic [ADDR_W-1:0] ca;
        logic [DATA_W-1:0] cd;
        req0_valid = v0; req0_we = w0; req0_addr = a0; req0_wdata = d0;
        req1_valid = v1; req1_we = w1; req1_addr = a1; req1_wdata = d1;
        @(negedge clk);
        free = (cyc >= next_free);
        hs   = free && (v0 || v1);
        win  = (v0 && v1) ? !lg : v1;
        chk("req0_ready", req0_ready, hs && !win);
        chk("req1_ready", req1_ready, hs &&  win);
        if (cyc == op_cyc) begin
            chk("ram_ce", ram_ce, 1);
            chk("ram_we", ram_we, op_we);
            chk("ram_addr", ram_addr, op_addr);
            if (op_we) chk("ram_din", ram_din, op_din);
        end else begin
            chk("ram_ce_idle", ram_ce, 0);
            chk("ram_we_idle", ram_we, 0);
        end
        if (cyc == rsp_cyc) begin
            chk("rsp0_valid", rsp0_valid, !rsp_own);
            chk("rsp1_valid", rsp1_valid,  rsp_own);
            chk("rsp_data", rsp_data, rsp_dat);
        end else begin
            chk("rsp0_valid_idle", rsp0_valid, 0);
            chk("rsp1_valid_idle", rsp1_valid, 0);
        end
        if (hs) begin
            cw = win ? w1 : w0;
            ca = win ? a1 : a0;
            cd = win ? d1 : d0;
            if (win) grants1++; else grants0++;
            lg      = win;
            op_cyc  = cyc + 1;
            op_we   = cw;
            op_addr = ca;
            op_din  = cd;
            if (cw) begin
                ref_mem[ca] = cd;
                next_free   = cyc + 2;
            end else begin
                rsp_cyc   = cyc + 2;
                rsp_dat   = ref_mem[ca];
                rsp_own   = win;
                next_free = cyc + 3;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Asynchronous reset pulse started just after a rising edge.
    task automatic pulse_reset();
        req0_valid = 0; req1_valid = 0;
        rst_n = 1'b0;
        #1;
        chk("rst_ram_ce", ram_ce, 0);
        chk("rst_ram_we", ram_we, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_ram_din", ram_din, 0);
        chk("rst_rsp0", rsp0_valid, 0);
        chk("rst_rsp1", rsp1_valid, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_ready0", req0_ready, 0);
        chk("rst_ready1", req1_ready, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
        model_reset();
    endtask

    int g0, g1;

    initial begin
        for (int i = 0; i < 16; i++) ref_mem[i] = '0;
        cyc = 0; grants0 = 0; grants1 = 0;
        model_reset();
        req0_valid = 0; req0_we = 0; req0_addr = 0; req0_wdata = 0;
        req1_valid = 0; req1_we = 0; req1_addr = 0; req1_wdata = 0;
        rst_n = 1'b0;
        #2;
        chk("init_ram_ce", ram_ce, 0);
        chk("init_ram_we", ram_we, 0);
        chk("init_ram_addr", ram_addr, 0);
        chk("init_ram_din", ram_din, 0);
        chk("init_rsp0", rsp0_valid, 0);
        chk("init_rsp1", rsp1_valid, 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Write 45 to address 6, then read it back through req0.
        cycle(1, 1, 6, 45, 0, 0, 0, 0);
        chk("wr_ram_addr_T1", ram_addr, 6);
        chk("wr_ram_din_T1", ram_din, 45);
        idle(1);
        cycle(1, 0, 6, 0, 0, 0, 0, 0);
        idle(1);
        chk("rd_rsp0_T2", rsp0_valid, 1);
        chk("rd_data_T2", rsp_data, 45);
        idle(2);

        // req1 stores 23 at address 14.
        cycle(0, 0, 0, 0, 1, 1, 14, 23);
        idle(1);

        // Both hold reads: grants alternate, responses go to the owner.
        g0 = grants0; g1 = grants1;
        for (int i = 0; i < 12; i++) cycle(1, 0, 6, 0, 1, 0, 14, 0);
        chk("alt_grants0", grants0 - g0, 2);
        chk("alt_grants1", grants1 - g1, 2);
        idle(3);

        // Write handshake; during ISSUE req1 rises and req0 changes its
        // addr/wdata. RAM must still see the captured command.
        cycle(1, 1, 3, 8'h5A, 0, 0, 0, 0);
        cycle(1, 1, 9, 8'hFF, 1, 0, 14, 0);
        chk("issue_addr_held", ram_addr, 3);
        chk("issue_din_held", ram_din, 8'h5A);
        cycle(1, 1, 9, 8'hFF, 1, 0, 14, 0);
        idle(4);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  ADDR_W'($urandom), DATA_W'($urandom),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 1),
                  ADDR_W'($urandom), DATA_W'($urandom));
        end
        idle(4);

        // Read in flight, reset asserted during RDWAIT.
        cycle(0, 0, 0, 0, 1, 0, 14, 0);
        idle(1);
        pulse_reset();
        idle(2);
        // First tie after reset goes to req0.
        cycle(1, 0, 3, 0, 1, 0, 6, 0);
        idle(3);

        for (int i = 0; i < 200; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 1),
                  ADDR_W'($urandom), DATA_W'($urandom),
                  $urandom_range(0, 1), $urandom_range(0, 1),
                  ADDR_W'($urandom), DATA_W'($urandom));
        end
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
